// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: button, time and alarm signals between the watch mode controller and its neighbours
interface clock_mode_ctrl_if;
    logic       iTick;
    logic       iBtnMode, iBtnRunStop, iBtnInc, iBtnDec, iBtnLeft, iBtnRight;
    logic [6:0] iClkHour, iClkMin, iClkSec;
    logic [1:0] iClkEditState;
    logic       oClkRunStop, oClkInc, oClkDec, oClkLeft, oClkRight;
    logic       oSwRunStop, oSwClear;
    logic [1:0] oMode;
    logic [6:0] oAlarmHour, oAlarmMin;
    logic       oAlarmEn, oAlarmField;
    logic       oRing, oSnooze;

    modport slave (
        input  iTick, iBtnMode, iBtnRunStop, iBtnInc, iBtnDec, iBtnLeft, iBtnRight,
        input  iClkHour, iClkMin, iClkSec, iClkEditState,
        output oClkRunStop, oClkInc, oClkDec, oClkLeft, oClkRight, oSwRunStop, oSwClear,
        output oMode, oAlarmHour, oAlarmMin, oAlarmEn, oAlarmField, oRing, oSnooze
    );

    modport master (
        output iTick, iBtnMode, iBtnRunStop, iBtnInc, iBtnDec, iBtnLeft, iBtnRight,
        output iClkHour, iClkMin, iClkSec, iClkEditState,
        input  oClkRunStop, oClkInc, oClkDec, oClkLeft, oClkRight, oSwRunStop, oSwClear,
        input  oMode, oAlarmHour, oAlarmMin, oAlarmEn, oAlarmField, oRing, oSnooze
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: watch mode FSM, registered button routing, alarm registers and ring/snooze FSM
module clock_mode_ctrl #(
    parameter int RING_TICKS   = 6000,
    parameter int SNOOZE_TICKS = 30000
) (
    input logic             iClk,
    input logic             iRst,
    clock_mode_ctrl_if.slave bus
);
    typedef enum logic [1:0] {MODE_CLOCK, MODE_SW, MODE_ALARM} mode_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_t;

    mode_t       mode_q, mode_d;
    alarm_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fired_q, fired_d;
    logic [6:0]  hour_q, hour_d, min_q, min_d;
    logic        en_q, en_d, field_q, field_d;
    logic [4:0]  clk_q, clk_d;
    logic [1:0]  sw_q, sw_d;
    logic        any_btn, ringing, mode_acc, route, match;

    always_comb begin
        any_btn  = bus.iBtnMode | bus.iBtnRunStop | bus.iBtnInc | bus.iBtnDec | bus.iBtnLeft | bus.iBtnRight;
        ringing  = state_q == A_RING;
        mode_acc = bus.iBtnMode && bus.iClkEditState == 2'd0 && !ringing;
        route    = !mode_acc && !ringing;
        mode_d   = !mode_acc ? mode_q : mode_q == MODE_CLOCK ? MODE_SW : mode_q == MODE_SW ? MODE_ALARM : MODE_CLOCK;
        clk_d    = (route && mode_q == MODE_CLOCK)
                 ? {bus.iBtnRunStop, bus.iBtnInc, bus.iBtnDec, bus.iBtnLeft, bus.iBtnRight} : 5'd0;
        sw_d     = (route && mode_q == MODE_SW) ? {bus.iBtnRunStop, bus.iBtnDec} : 2'd0;
        en_d     = en_q;
        field_d  = field_q;
        hour_d   = hour_q;
        min_d    = min_q;
        if (route && mode_q == MODE_ALARM) begin
            if (bus.iBtnRunStop)
                en_d = !en_q;
            else if (bus.iBtnLeft || bus.iBtnRight)
                field_d = !field_q;
            else if (bus.iBtnInc && field_q)
                hour_d = hour_q == 7'd12 ? 7'd1 : hour_q + 7'd1;
            else if (bus.iBtnInc)
                min_d = min_q == 7'd59 ? 7'd0 : min_q + 7'd1;
            else if (bus.iBtnDec && field_q)
                hour_d = hour_q == 7'd1 ? 7'd12 : hour_q - 7'd1;
            else if (bus.iBtnDec)
                min_d = min_q == 7'd0 ? 7'd59 : min_q - 7'd1;
        end
        match   = en_q && bus.iClkEditState == 2'd0 && bus.iClkHour == hour_q
               && bus.iClkMin == min_q && bus.iClkSec == 7'd0;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en_q) begin
            state_d = A_IDLE;
            cnt_d   = 16'd0;
        end else if (state_q == A_IDLE) begin
            state_d = (match && !fired_q) ? A_RING : A_IDLE;
            cnt_d   = 16'd0;
        end else if (ringing && any_btn) begin
            state_d = bus.iBtnRunStop ? A_IDLE : A_SNOOZE;
            cnt_d   = 16'd0;
        end else if (ringing && bus.iTick) begin
            state_d = cnt_q == 16'(RING_TICKS - 1) ? A_IDLE : A_RING;
            cnt_d   = cnt_q == 16'(RING_TICKS - 1) ? 16'd0 : cnt_q + 16'd1;
        end else if (state_q == A_SNOOZE && bus.iTick) begin
            state_d = cnt_q == 16'(SNOOZE_TICKS - 1) ? A_RING : A_SNOOZE;
            cnt_d   = cnt_q == 16'(SNOOZE_TICKS - 1) ? 16'd0 : cnt_q + 16'd1;
        end
        // one trigger per matching minute: latch on firing, release once the minute moves on
        fired_d = (state_q == A_IDLE && state_d == A_RING) ? 1'b1 : bus.iClkMin != min_q ? 1'b0 : fired_q;
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mode_q  <= MODE_CLOCK;
            state_q <= A_IDLE;
            cnt_q   <= 16'd0;
            fired_q <= 1'b0;
            hour_q  <= 7'd12;
            min_q   <= 7'd0;
            en_q    <= 1'b0;
            field_q <= 1'b0;
            clk_q   <= 5'd0;
            sw_q    <= 2'd0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fired_q <= fired_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            en_q    <= en_d;
            field_q <= field_d;
            clk_q   <= clk_d;
            sw_q    <= sw_d;
        end
    end

    assign {bus.oClkRunStop, bus.oClkInc, bus.oClkDec, bus.oClkLeft, bus.oClkRight} = clk_q;
    assign {bus.oSwRunStop, bus.oSwClear} = sw_q;
    assign bus.oMode       = mode_q;
    assign bus.oAlarmHour  = hour_q;
    assign bus.oAlarmMin   = min_q;
    assign bus.oAlarmEn    = en_q;
    assign bus.oAlarmField = field_q;
    assign bus.oRing       = state_q == A_RING;
    assign bus.oSnooze     = state_q == A_SNOOZE;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: table-driven routing/alarm-set vectors plus hand sequences for ring, snooze and reset
module tb_clock_mode_ctrl;
    logic iClk = 1'b0;
    logic iRst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    clock_mode_ctrl_if bus();
    clock_mode_ctrl #(.RING_TICKS(4), .SNOOZE_TICKS(3)) dut (.iClk(iClk), .iRst(iRst), .bus(bus));

    always #5 iClk = ~iClk;

    typedef struct {
        logic [5:0] btn;
        logic [1:0] edit;
        logic [1:0] mode;
        logic [4:0] clk;
        logic [1:0] sw;
        logic [6:0] hour;
        logic [6:0] min;
        logic       en;
        logic       field;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_btn(input logic [5:0] b);
        {bus.iBtnMode, bus.iBtnRunStop, bus.iBtnInc, bus.iBtnDec, bus.iBtnLeft, bus.iBtnRight} = b;
    endtask

    task automatic drive(input logic [5:0] b, input logic [1:0] edit);
        @(negedge iClk);
        set_btn(b);
        bus.iClkEditState = edit;
        @(negedge iClk);
        set_btn(6'd0);
    endtask

    task automatic tick();
        @(negedge iClk);
        bus.iTick = 1'b1;
        @(negedge iClk);
        bus.iTick = 1'b0;
    endtask

    task automatic set_time(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
        @(negedge iClk);
        bus.iClkHour = h;
        bus.iClkMin  = m;
        bus.iClkSec  = s;
    endtask

    function automatic logic [4:0] clk_out();
        return {bus.oClkRunStop, bus.oClkInc, bus.oClkDec, bus.oClkLeft, bus.oClkRight};
    endfunction

    initial begin
        vecs[0]  = '{6'b001000, 2'd0, 2'd0, 5'b01000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[1]  = '{6'b100000, 2'd0, 2'd1, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[2]  = '{6'b001000, 2'd0, 2'd1, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[3]  = '{6'b010100, 2'd0, 2'd1, 5'b00000, 2'b11, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[4]  = '{6'b000011, 2'd0, 2'd1, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[5]  = '{6'b100000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[6]  = '{6'b001000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd1,  1'b0, 1'b0};
        vecs[7]  = '{6'b000100, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[8]  = '{6'b000100, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd59, 1'b0, 1'b0};
        vecs[9]  = '{6'b001000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[10] = '{6'b000010, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b1};
        vecs[11] = '{6'b001000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd1,  7'd0,  1'b0, 1'b1};
        vecs[12] = '{6'b000100, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b1};
        vecs[13] = '{6'b000100, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd11, 7'd0,  1'b0, 1'b1};
        vecs[14] = '{6'b001000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b1};
        vecs[15] = '{6'b000001, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[16] = '{6'b011000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b1, 1'b0};
        vecs[17] = '{6'b010000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[18] = '{6'b100000, 2'd0, 2'd0, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[19] = '{6'b100000, 2'd1, 2'd0, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[20] = '{6'b101000, 2'd0, 2'd1, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[21] = '{6'b100000, 2'd0, 2'd2, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[22] = '{6'b100000, 2'd0, 2'd0, 5'b00000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[23] = '{6'b011111, 2'd0, 2'd0, 5'b11111, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};
        vecs[24] = '{6'b001000, 2'd2, 2'd0, 5'b01000, 2'b00, 7'd12, 7'd0,  1'b0, 1'b0};

        bus.iTick = 1'b0;
        set_btn(6'd0);
        bus.iClkHour = 7'd1;
        bus.iClkMin = 7'd5;
        bus.iClkSec = 7'd3;
        bus.iClkEditState = 2'd0;
        repeat (3) @(negedge iClk);
        check("rst_mode", 32'(bus.oMode), 0);
        check("rst_hour", 32'(bus.oAlarmHour), 12);
        check("rst_min", 32'(bus.oAlarmMin), 0);
        check("rst_en_field", {bus.oAlarmEn, bus.oAlarmField}, 0);
        check("rst_pulses", {clk_out(), bus.oSwRunStop, bus.oSwClear, bus.oRing, bus.oSnooze}, 0);
        iRst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].btn, vecs[i].edit);
            check($sformatf("v%0d_mode", i), 32'(bus.oMode), 32'(vecs[i].mode));
            check($sformatf("v%0d_clk", i), 32'(clk_out()), 32'(vecs[i].clk));
            check($sformatf("v%0d_sw", i), {bus.oSwRunStop, bus.oSwClear}, 32'(vecs[i].sw));
            check($sformatf("v%0d_hour", i), 32'(bus.oAlarmHour), 32'(vecs[i].hour));
            check($sformatf("v%0d_min", i), 32'(bus.oAlarmMin), 32'(vecs[i].min));
            check($sformatf("v%0d_en_field", i), {bus.oAlarmEn, bus.oAlarmField}, {vecs[i].en, vecs[i].field});
            @(negedge iClk);
            check($sformatf("v%0d_width", i), {clk_out(), bus.oSwRunStop, bus.oSwClear}, 0);
        end

        // arm the alarm for 7:30 from CLOCK mode
        drive(6'b100000, 2'd0);
        drive(6'b100000, 2'd0);
        repeat (30) drive(6'b001000, 2'd0);
        drive(6'b000010, 2'd0);
        repeat (5) drive(6'b000100, 2'd0);
        drive(6'b010000, 2'd0);
        check("arm_hour", 32'(bus.oAlarmHour), 7);
        check("arm_min", 32'(bus.oAlarmMin), 30);
        check("arm_en", 32'(bus.oAlarmEn), 1);
        drive(6'b100000, 2'd0);
        check("arm_mode_clock", 32'(bus.oMode), 0);

        // match cycle carries an Inc that must still be routed
        @(negedge iClk);
        bus.iClkHour = 7'd7;
        bus.iClkMin = 7'd30;
        bus.iClkSec = 7'd0;
        set_btn(6'b001000);
        check("pre_match_ring", 32'(bus.oRing), 0);
        @(negedge iClk);
        set_btn(6'd0);
        check("match_ring", 32'(bus.oRing), 1);
        check("match_inc_routed", 32'(bus.oClkInc), 1);
        tick();
        tick();
        check("ring_after_2_ticks", 32'(bus.oRing), 1);
        drive(6'b010000, 2'd0);
        check("dismiss_ring", 32'(bus.oRing), 0);
        check("dismiss_consumed", 32'(bus.oClkRunStop), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            check($sformatf("no_retrigger%0d", i), {bus.oRing, bus.oSnooze}, 0);
        end

        // minute moves on and back: fires again, then snooze and timeout
        set_time(7'd7, 7'd31, 7'd0);
        set_time(7'd7, 7'd30, 7'd0);
        @(negedge iClk);
        check("retrigger_ring", 32'(bus.oRing), 1);
        drive(6'b001000, 2'd0);
        check("snooze_on", {bus.oRing, bus.oSnooze}, 1);
        check("snooze_inc_consumed", 32'(bus.oClkInc), 0);
        tick();
        tick();
        check("snooze_2_ticks", {bus.oRing, bus.oSnooze}, 1);
        tick();
        check("snooze_rering", {bus.oRing, bus.oSnooze}, 2);
        tick();
        tick();
        tick();
        check("ring_3_ticks", 32'(bus.oRing), 1);
        tick();
        check("ring_timeout", {bus.oRing, bus.oSnooze}, 0);
        repeat (3) @(negedge iClk);
        check("timeout_no_retrigger", 32'(bus.oRing), 0);

        // Mode pulse while ringing snoozes without changing mode; disarming in snooze forces idle
        set_time(7'd7, 7'd31, 7'd0);
        set_time(7'd7, 7'd30, 7'd0);
        @(negedge iClk);
        check("ring3", 32'(bus.oRing), 1);
        drive(6'b100000, 2'd0);
        check("ring_mode_consumed", 32'(bus.oMode), 0);
        check("ring_mode_snooze", 32'(bus.oSnooze), 1);
        drive(6'b100000, 2'd0);
        check("snooze_mode_routed", 32'(bus.oMode), 1);
        drive(6'b100000, 2'd0);
        drive(6'b010000, 2'd0);
        check("disarm_en", 32'(bus.oAlarmEn), 0);
        @(negedge iClk);
        check("disarm_idle", {bus.oRing, bus.oSnooze}, 0);

        // async reset mid-ring
        drive(6'b010000, 2'd0);
        set_time(7'd7, 7'd31, 7'd0);
        set_time(7'd7, 7'd30, 7'd0);
        @(negedge iClk);
        check("ring4", 32'(bus.oRing), 1);
        #2 iRst = 1'b1;
        #1;
        check("async_rst_ring", {bus.oRing, bus.oSnooze}, 0);
        check("async_rst_en", 32'(bus.oAlarmEn), 0);
        @(negedge iClk);
        iRst = 1'b0;
        repeat (3) @(negedge iClk);
        check("post_rst_no_ring", 32'(bus.oRing), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
